matmul_ctrl: RTL and testbench
==============================

MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameters SHALL be: N, 3, matrix dimension; A_BASE, 0, base address of A (row-major); B_BASE, 9, base address of B; C_BASE, 18, base address of result C.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 busy  output  1  high while a run is in progress (SEQ or DONE state).
REQ-006 done  output  1  one-cycle pulse when a run completes.
REQ-007 ovf  output  1  sticky flag: some C element exceeded 255 in the current or last run.
REQ-008 host_addr, host_wdata, host_we, host_re  input  5, 8, 1, 1  host access port to the 32x8 memory.
REQ-009 host_rdata  output  8  read data returned to the host; host_grant  output  1  high when the host owns the memory.
REQ-010 mem_addr, mem_wdata, mem_we, mem_re  output  5, 8, 1, 1  drive the 32x8 single-port memory (memWrite, memRead, addr, data_in).
REQ-011 mem_rdata  input  8  memory output; combinational, valid in the same cycle as mem_addr and mem_re.

Function
REQ-012 Operation SHALL compute C = A x B over unsigned 8-bit elements, with C[i][j] = sum over k of A[i][k]*B[k][j].
REQ-013 Addressing SHALL be A: A_BASE+i*N+k; B: B_BASE+k*N+j; C: C_BASE+i*N+j; all 5-bit.
REQ-014 The state machine SHALL have states IDLE, RD_A, RD_B, WR and DONE; SEQ denotes RD_A, RD_B and WR.
REQ-015 IDLE -> RD_A SHALL occur on the edge where start=1; on that edge i, j, k and acc are cleared and ovf is cleared.
REQ-016 In RD_A: mem_re=1, addr = A address; mem_rdata SHALL be captured into a_reg at the end of the cycle; the next state is RD_B.
REQ-017 In RD_B: mem_re=1, addr = B address; acc <= acc + a_reg*mem_rdata.
REQ-018 RD_B transitions: k<N-1 -> k++ and go to RD_A; otherwise go to WR.
REQ-019 The accumulator SHALL be 18 bits wide and SHALL NOT overflow for N=3.
REQ-020 In WR: mem_we=1, addr = C address, mem_wdata = acc[7:0] (wrap modulo 256).
REQ-021 In WR, ovf SHALL be set if acc>255; acc and k are then cleared.
REQ-022 WR advances j, wrapping to 0 with i++.
REQ-023 After the last element (i=j=N-1), WR SHALL go to DONE; otherwise it goes to RD_A.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-025 Latency: with start seen in cycle 0, SEQ SHALL occupy cycles 1..63 (7 cycles per element), done=1 in cycle 64, and IDLE in cycle 65.
REQ-026 mem_re and mem_we SHALL never be high together.
REQ-027 In IDLE the host port SHALL pass straight through to the memory port, with host_grant=1 and host_rdata=mem_rdata.
REQ-028 When busy=1: host_grant=0, host_we and host_re are ignored, and host_rdata=0.
REQ-029 start while busy SHALL be ignored; start held high SHALL begin a new run in cycle 65.
REQ-030 Outputs in IDLE with no host activity SHALL be mem_re=mem_we=0.

Reset
REQ-031 While rst=0: state=IDLE, i=j=k=0, acc=0, a_reg=0, busy=0, done=0, ovf=0, mem_we=0, mem_re=0.
REQ-032 Reset mid-run SHALL abort immediately with no further memory writes; C elements already written SHALL remain in memory.
REQ-033 The first start after reset deassertion SHALL behave as in REQ-015.

Structure
REQ-034 The state encoding, N and the default base addresses SHALL live in a shared package, matmul_pkg.
REQ-035 The multiply-accumulate SHALL be a single sub-module, mac8: 8x8 unsigned multiply plus 18-bit add, with clear and enable inputs.
REQ-036 The memory SHALL be external to this block; the controller contains no storage array.

Verification
REQ-037 Identity test: host loads A=I and B=1..9, then pulses start -> done in cycle 64; host reads 18..26 = 1..9; ovf=0.
REQ-038 All-twos test: A and B all 2 -> every C element = 12; ovf=0.
REQ-039 Overflow test: A and B all 200 -> every C element = 192 (120000 mod 256); ovf=1, and ovf is cleared at the next start.
REQ-040 Host write during busy: host write 0xFF to address 0 in cycle 10 -> host_grant=0, address 0 unchanged, C correct.
REQ-041 Reset mid-run: rst=0 in cycle 30 -> busy=0 and no mem_we afterwards; a restart yields the correct C.
REQ-042 Back-to-back runs: start held high -> second run begins in cycle 65; exactly one done pulse per run.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 matrix-multiply controller: default geometry,
// bus widths, FSM state encoding and the row-major address helper.
package matmul_pkg;

  localparam int N_DEF      = 3;
  localparam int A_BASE_DEF = 0;
  localparam int B_BASE_DEF = 9;
  localparam int C_BASE_DEF = 18;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Row-major element address, wrapped to the 5-bit memory space.
  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] row,
    input logic [ADDR_W-1:0] col,
    input logic [ADDR_W-1:0] dim
  );
    return base + row * dim + col;
  endfunction

endpackage

// File: rtl/matmul_ctrl_mac8.sv
// mac8: 8x8 unsigned multiply feeding an 18-bit accumulator.
// clr has priority over en so a clear and an accumulate never collide.
module mac8
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_q;

  // Next accumulator value: clear, add one product, or hold.
  always_comb begin
    prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W - 2*DATA_W){1'b0}}, prod};
    end
  end

  // Accumulator register, cleared by the active-low asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_ctrl.sv
// matmul_ctrl: sequences C = A x B over an external 32x8 single-port memory.
// Each C element takes 7 cycles (three RD_A/RD_B pairs, then one WR). While
// idle the host port is passed straight through to the memory; while busy
// the controller owns the memory and host requests are dropped.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int A_BASE = A_BASE_DEF,
  parameter int B_BASE = B_BASE_DEF,
  parameter int C_BASE = C_BASE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_we,
  input  logic              host_re,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     j_q, j_d;
  logic [CW-1:0]     k_q, k_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              mac_clr;
  logic              mac_en;
  logic [ACC_W-1:0]  acc;

  logic [ADDR_W-1:0] ctl_addr;
  logic              ctl_re;
  logic              ctl_we;
  logic              idle;

  // The accumulator adds a_reg * B element during RD_B and is cleared on the
  // start edge and after each C element is written.
  mac8 u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_q),
    .b   (mem_rdata),
    .acc (acc)
  );

  // Next-state, loop-index and flag logic for the sequencer.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    ovf_d   = ovf_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_A;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          mac_clr = 1'b1;
        end
      end
      S_RD_A: begin
        a_d     = mem_rdata;
        state_d = S_RD_B;
      end
      S_RD_B: begin
        mac_en = 1'b1;
        if (k_q != LAST) begin
          k_d     = k_q + CW'(1);
          state_d = S_RD_A;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        mac_clr = 1'b1;
        k_d     = '0;
        if (acc > ACC_W'(255)) begin
          ovf_d = 1'b1;
        end
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + CW'(1);
            state_d = S_RD_A;
          end
        end else begin
          j_d     = j_q + CW'(1);
          state_d = S_RD_A;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // busy/done are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state and registered status outputs; reset aborts a run at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Controller-side memory request for the current phase of the sequence.
  always_comb begin
    ctl_addr = '0;
    ctl_re   = 1'b0;
    ctl_we   = 1'b0;
    case (state_q)
      S_RD_A: begin
        ctl_re   = 1'b1;
        ctl_addr = elem_addr(ADDR_W'(A_BASE), ADDR_W'(i_q), ADDR_W'(k_q), ADDR_W'(N));
      end
      S_RD_B: begin
        ctl_re   = 1'b1;
        ctl_addr = elem_addr(ADDR_W'(B_BASE), ADDR_W'(k_q), ADDR_W'(j_q), ADDR_W'(N));
      end
      S_WR: begin
        ctl_we   = 1'b1;
        ctl_addr = elem_addr(ADDR_W'(C_BASE), ADDR_W'(i_q), ADDR_W'(j_q), ADDR_W'(N));
      end
      default: begin
        ctl_addr = '0;
      end
    endcase
  end

  assign idle = (state_q == S_IDLE);

  // Memory port arbitration: host passthrough when idle, controller otherwise.
  // A host write wins over a simultaneous host read so re/we stay exclusive.
  always_comb begin
    if (idle) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_we     = host_we;
      mem_re     = host_re & ~host_we;
      host_grant = 1'b1;
      host_rdata = mem_rdata;
    end else begin
      mem_addr   = ctl_addr;
      mem_wdata  = acc[DATA_W-1:0];
      mem_we     = ctl_we;
      mem_re     = ctl_re;
      host_grant = 1'b0;
      host_rdata = '0;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: external 32x8 memory, run-schedule scoreboard checked
// every cycle, and directed scenarios with hand-computed results.
`timescale 1ns/1ps
module tb_matmul_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, ovf;
  logic [4:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_we = 1'b0;
  logic       host_re = 1'b0;
  logic [7:0] host_rdata;
  logic       host_grant;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we, mem_re;
  logic [7:0] mem_rdata;

  logic [7:0] mem [32];
  logic [7:0] ma [9];
  logic [7:0] mb [9];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matmul_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_rdata (host_rdata),
    .host_grant (host_grant),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  // External single-port memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t = cycle number within the current run (start seen in cycle 0);
  // t < 1 or t > 64 means idle.
  int          t = -1;
  logic [17:0] exp_c [9];
  logic        exp_ovf = 1'b0;

  function automatic logic [17:0] c_elem(input int e);
    int s = 0;
    for (int k = 0; k < 3; k++) s += int'(ma[(e / 3) * 3 + k]) * int'(mb[k * 3 + (e % 3)]);
    return 18'(s);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t       <= -1;
      exp_ovf <= 1'b0;
    end else if (t < 1 || t > 64) begin
      if (start) begin
        t       <= 1;
        exp_ovf <= 1'b0;
        for (int e = 0; e < 9; e++) exp_c[e] <= c_elem(e);
      end else begin
        t <= -1;
      end
    end else begin
      if (t <= 63 && (t - 1) % 7 == 6 && exp_c[(t - 1) / 7] > 18'd255) exp_ovf <= 1'b1;
      t <= t + 1;
    end
  end

  // Per-cycle compare of every DUT output against the run schedule.
  always @(negedge clk) begin
    int e, p, ii, jj, kk;
    if (t >= 1 && t <= 63) begin
      e  = (t - 1) / 7;
      p  = (t - 1) % 7;
      ii = e / 3;
      jj = e % 3;
      chk("seq_busy", int'(busy), 1);
      chk("seq_done", int'(done), 0);
      chk("seq_grant", int'(host_grant), 0);
      chk("seq_host_rdata", int'(host_rdata), 0);
      if (p == 6) begin
        chk("wr_we", int'(mem_we), 1);
        chk("wr_re", int'(mem_re), 0);
        chk("wr_addr", int'(mem_addr), 18 + ii * 3 + jj);
        chk("wr_data", int'(mem_wdata), int'(exp_c[e][7:0]));
      end else begin
        kk = p / 2;
        chk("rd_re", int'(mem_re), 1);
        chk("rd_we", int'(mem_we), 0);
        chk("rd_addr", int'(mem_addr), (p % 2 == 0) ? (ii * 3 + kk) : (9 + kk * 3 + jj));
      end
    end else if (t == 64) begin
      chk("done_busy", int'(busy), 1);
      chk("done_pulse", int'(done), 1);
      chk("done_re", int'(mem_re), 0);
      chk("done_we", int'(mem_we), 0);
      chk("done_grant", int'(host_grant), 0);
    end else begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_grant", int'(host_grant), 1);
      chk("idle_we", int'(mem_we), int'(host_we));
      chk("idle_re", int'(mem_re), int'(host_re));
      chk("idle_addr", int'(mem_addr), int'(host_addr));
      if (host_we) chk("idle_wdata", int'(mem_wdata), int'(host_wdata));
      if (host_re) chk("idle_rdata", int'(host_rdata), int'(mem[host_addr]));
    end
    chk("ovf", int'(ovf), int'(exp_ovf));
  end

  // ---------------- host helpers ----------------
  task automatic hw(input int a, input int d);
    host_addr  = 5'(a);
    host_wdata = 8'(d);
    host_we    = 1'b1;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic hr(input int a, output int d);
    host_addr = 5'(a);
    host_re   = 1'b1;
    @(negedge clk);
    d = int'(host_rdata);
    @(posedge clk); #1;
    host_re = 1'b0;
  endtask

  task automatic load();
    for (int x = 0; x < 9; x++) begin
      hw(x, int'(ma[x]));
      hw(9 + x, int'(mb[x]));
    end
  endtask

  // Wait for done, starting in cycle c0 of the run; returns the done cycle.
  task automatic wait_done(input int c0, output int lat);
    lat = c0;
    while (lat < 200) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("done_timeout", lat, 64);
    @(posedge clk); #1;
  endtask

  task automatic run(output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, lat);
  endtask

  task automatic check_c(input string nm, input int e, input int expv);
    int d;
    hr(18 + e, d);
    chk(nm, d, expv);
  endtask

  int lat, d, nd, d1, d2;
  int c_dir [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_re", int'(mem_re), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Identity x 1..9
    for (int x = 0; x < 9; x++) begin
      ma[x] = (x / 3 == x % 3) ? 8'd1 : 8'd0;
      mb[x] = 8'(x + 1);
    end
    load();
    run(lat);
    chk("ident_latency", lat, 64);
    chk("model_pin_c4", int'(exp_c[4]), 5);
    for (int x = 0; x < 9; x++) check_c("ident_c", x, x + 1);
    chk("ident_ovf", int'(ovf), 0);

    // All twos
    for (int x = 0; x < 9; x++) begin
      ma[x] = 8'd2;
      mb[x] = 8'd2;
    end
    load();
    run(lat);
    chk("twos_latency", lat, 64);
    for (int x = 0; x < 9; x++) check_c("twos_c", x, 12);
    chk("twos_ovf", int'(ovf), 0);

    // Overflow: 3*200*200 = 120000, 120000 mod 256 = 192
    for (int x = 0; x < 9; x++) begin
      ma[x] = 8'd200;
      mb[x] = 8'd200;
    end
    load();
    run(lat);
    chk("model_pin_big", int'(exp_c[0]), 120000);
    for (int x = 0; x < 9; x++) check_c("ovf_c", x, 192);
    chk("ovf_set", int'(ovf), 1);

    // Host write during busy; ovf cleared by the new start
    for (int x = 0; x < 9; x++) begin
      ma[x] = 8'(x + 1);
      mb[x] = 8'(9 - x);
    end
    load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ovf_clr", int'(ovf), 0);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_grant", int'(host_grant), 0);
    hw(0, 255);
    wait_done(11, lat);
    chk("hostwr_latency", lat, 64);
    hr(0, d);
    chk("hostwr_a0", d, 1);
    for (int x = 0; x < 9; x++) check_c("hostwr_c", x, c_dir[x]);

    // Reset mid-run in cycle 30: elements 0..3 already written, rest untouched
    for (int x = 0; x < 9; x++) hw(18 + x, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_we", int'(mem_we), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int x = 0; x < 9; x++) check_c("midrst_c", x, (x < 4) ? c_dir[x] : 0);
    run(lat);
    chk("restart_latency", lat, 64);
    for (int x = 0; x < 9; x++) check_c("restart_c", x, c_dir[x]);

    // Back-to-back: start held through cycle 65
    nd = 0;
    d1 = 0;
    d2 = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = c;
        else d2 = c;
      end
      @(posedge clk); #1;
      if (c == 65) start = 1'b0;
    end
    chk("b2b_dones", nd, 2);
    chk("b2b_first", d1, 64);
    chk("b2b_second", d2, 129);
    for (int x = 0; x < 9; x++) check_c("b2b_c", x, c_dir[x]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
